// File: rtl/io_scan_pkg.sv
// Shared types and constants for the IO-tile scan-chain sequencer.
package io_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        CAP,
        SHIFT,
        RESP
    } scan_state_t;

    typedef logic [1:0] scan_op_t;

    localparam scan_op_t OP_CLEAR    = 2'd0;
    localparam scan_op_t OP_CAPSHIFT = 2'd1;
    localparam scan_op_t OP_SHIFT    = 2'd2;

    localparam int SLOT_CYC = 4;
    localparam int SR_CYC   = 2;

endpackage

// File: rtl/io_scan_phase_gen.sv
// Slot-phase counter: emits sample, SC0/SC1 gate strobes and end-of-slot.
// Capture slots run SC0,gap,SC1,gap; shift slots run sample,SC0,gap,SC1.
module io_scan_phase_gen
    import io_scan_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic cap_i,
    output logic sample_o,
    output logic sc0_o,
    output logic sc1_o,
    output logic slot_end_o
);

    localparam int PH_W = $clog2(SLOT_CYC);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    assign phase_d = en_i ? phase_q + PH_W'(1) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // One idle phase always separates an SC0 pulse from an SC1 pulse, also across slots.
    assign sample_o   = en_i & ~cap_i & (phase_q == PH_W'(0));
    assign sc0_o      = en_i & (cap_i ? (phase_q == PH_W'(0)) : (phase_q == PH_W'(1)));
    assign sc1_o      = en_i & (cap_i ? (phase_q == PH_W'(2)) : (phase_q == PH_W'(3)));
    assign slot_end_o = en_i & (phase_q == PH_W'(SLOT_CYC - 1));

endmodule

// File: rtl/io_scan_seq_ctrl.sv
// IO-ring scan sequencer: host command in, scan controls out, captured bits returned.
// Optional command/response parity is enabled by defining IO_SCAN_CTRL_PARITY_EN.
module io_scan_seq_ctrl
    import io_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 pi_pad_clk,
    input  logic                 pi_pad_rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  scan_op_t             cmd_op,
    input  logic [CHAIN_LEN-1:0] cmd_tx,
`ifdef IO_SCAN_CTRL_PARITY_EN
    input  logic                 cmd_par,
    output logic                 rsp_par,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_rx,
    output logic                 rsp_err,
    output logic                 SE0,
    output logic                 SE1,
    output logic                 SC0,
    output logic                 SC1,
    output logic                 SR,
    output logic                 scan_si,
    input  logic                 scan_so,
    output scan_state_t          dbg_state_o
);

    localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    scan_state_t          state_q, state_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [1:0]           sr_q, sr_d;
    logic                 err_q, err_d;

    logic             in_scan;
    logic             sample;
    logic             slot_end;
    logic             par_bad;
    logic [IDX_W-1:0] bit_idx;

    assign in_scan = (state_q == CAP) || (state_q == SHIFT);
    assign bit_idx = bit_q[IDX_W-1:0];

`ifdef IO_SCAN_CTRL_PARITY_EN
    assign par_bad = cmd_par ^ (^cmd_tx);
`else
    assign par_bad = 1'b0;
`endif

    io_scan_phase_gen u_phase (
        .clk_i     (pi_pad_clk),
        .rst_ni    (pi_pad_rstn),
        .en_i      (in_scan),
        .cap_i     (state_q == CAP),
        .sample_o  (sample),
        .sc0_o     (SC0),
        .sc1_o     (SC1),
        .slot_end_o(slot_end)
    );

    always_ff @(posedge pi_pad_clk or negedge pi_pad_rstn) begin
        if (!pi_pad_rstn) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
        end
    end

    // Both ports use valid/ready: a transfer happens on a rising edge where both are high.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_d  = cmd_tx;
                    rx_d  = '0;
                    bit_d = '0;
                    sr_d  = '0;
                    err_d = 1'b0;
                    if (par_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        case (cmd_op)
                            OP_CLEAR:    state_d = CLR;
                            OP_CAPSHIFT: state_d = CAP;
                            OP_SHIFT:    state_d = SHIFT;
                            default: begin
                                err_d   = 1'b1;
                                state_d = RESP;
                            end
                        endcase
                    end
                end
            end
            CLR: begin
                sr_d = sr_q + 2'd1;
                if (sr_q == 2'(SR_CYC - 1)) state_d = RESP;
            end
            CAP: begin
                if (slot_end) state_d = SHIFT;
            end
            SHIFT: begin
                if (sample) rx_d[bit_idx] = scan_so;
                if (slot_end) begin
                    bit_d = bit_q + CNT_W'(1);
                    if (bit_q == CNT_W'(CHAIN_LEN - 1)) state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rx      = rx_q;
    assign rsp_err     = rsp_valid & err_q;
`ifdef IO_SCAN_CTRL_PARITY_EN
    assign rsp_par     = rsp_valid & (^rx_q);
`endif
    assign SE0         = (state_q == SHIFT);
    assign SE1         = in_scan;
    assign SR          = (state_q == CLR);
    assign scan_si     = (state_q == SHIFT) & tx_q[bit_idx];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_scan_seq_ctrl.sv
// Bench for io_scan_seq_ctrl with an 8-flop behavioural scan chain and a command-level model.
module tb_io_scan_seq_ctrl;
    import io_scan_pkg::*;

    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [L-1:0] cmd_tx = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [L-1:0] rsp_rx;
    logic         rsp_err;
    logic         se0, se1, sc0, sc1, sr, scan_si, scan_so;
    scan_state_t  dbg_state;
`ifdef IO_SCAN_CTRL_PARITY_EN
    logic         rsp_par;
`endif

    always #5 clk = ~clk;

    io_scan_seq_ctrl #(.CHAIN_LEN(L)) dut (
        .pi_pad_clk (clk),
        .pi_pad_rstn(rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_tx     (cmd_tx),
`ifdef IO_SCAN_CTRL_PARITY_EN
        .cmd_par    (^cmd_tx),
        .rsp_par    (rsp_par),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rx     (rsp_rx),
        .rsp_err    (rsp_err),
        .SE0        (se0),
        .SE1        (se1),
        .SC0        (sc0),
        .SC1        (sc1),
        .SR         (sr),
        .scan_si    (scan_si),
        .scan_so    (scan_so),
        .dbg_state_o(dbg_state)
    );

    // Behavioural chain: bit 0 is the flop driving scan_so, SC0 loads master, SC1 copies to slave.
    logic [L-1:0] chain_w = '0;
    logic [L-1:0] master_w = '0;
    logic [L-1:0] func_d = '0;
    logic         preload_req = 1'b0;
    logic [L-1:0] preload_val = '0;

    always @(posedge clk) begin
        if (preload_req) begin
            chain_w <= preload_val;
        end else if (sr) begin
            chain_w  <= '0;
            master_w <= '0;
        end else begin
            if (sc0) master_w <= se0 ? {scan_si, chain_w[L-1:1]} : func_d;
            if (sc1) chain_w <= master_w;
        end
    end
    assign scan_so = chain_w[0];

    int sc0_tot = 0, sc1_tot = 0, sr_tot = 0, viol_tot = 0;
    logic prev_sc0 = 1'b0, prev_sc1 = 1'b0;
    always @(negedge clk) begin
        if (sc0) sc0_tot++;
        if (sc1) sc1_tot++;
        if (sr) sr_tot++;
        if ((sc0 && sc1) || (sc0 && prev_sc1) || (sc1 && prev_sc0)) viol_tot++;
        prev_sc0 = sc0;
        prev_sc1 = sc1;
    end

    int errors = 0;
    int checks = 0;
    logic [L-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Command-level reference: what the host sees and what the chain holds afterwards.
    logic [L-1:0] model_chain = '0;

    task automatic model_cmd(input logic [1:0] op, input logic [L-1:0] tx, input logic [L-1:0] fd,
                             output logic [L-1:0] rx, output logic err, output int lat,
                             output int n_sc, output int n_sr);
        rx = '0; err = 1'b0; lat = 1; n_sc = 0; n_sr = 0;
        case (op)
            2'd0: begin lat = 3; n_sr = 2; model_chain = '0; end
            2'd1: begin rx = fd; lat = 4 * L + 5; n_sc = L + 1; model_chain = tx; end
            2'd2: begin rx = model_chain; lat = 4 * L + 1; n_sc = L; model_chain = tx; end
            default: err = 1'b1;
        endcase
    endtask

    task automatic preload(input logic [L-1:0] v);
        @(negedge clk);
        preload_req = 1'b1;
        preload_val = v;
        @(posedge clk);
        #1 preload_req = 1'b0;
        model_chain = v;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [L-1:0] tx, input int resp_delay,
                          input bit busy_poke);
        logic [L-1:0] e_rx;
        logic         e_err;
        int           e_lat, e_sc, e_sr;
        int           sc0_a, sc1_a, sr_a, viol_a, lat;
        logic [L-1:0] rx_first;
        model_cmd(op, tx, func_d, e_rx, e_err, e_lat, e_sc, e_sr);
        exp_q.push_back(e_rx);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_tx    = tx;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_tx    = L'($urandom);
        cmd_op    = 2'($urandom_range(0, 3));
        sc0_a = sc0_tot; sc1_a = sc1_tot; sr_a = sr_tot; viol_a = viol_tot;
        lat = 1;
        @(negedge clk);
        chk("cmd_ready_busy", cmd_ready, 0);
        while (rsp_valid !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        #1;
        chk("latency", lat, e_lat);
        chk("rsp_rx", rsp_rx, exp_q.pop_front());
        chk("rsp_err", rsp_err, e_err);
        chk("sc0_pulses", sc0_tot - sc0_a, e_sc);
        chk("sc1_pulses", sc1_tot - sc1_a, e_sc);
        chk("sr_cycles", sr_tot - sr_a, e_sr);
        chk("sc_overlap_adjacent", viol_tot - viol_a, 0);
        chk("resp_ctrl_low", {se0, se1, sc0, sc1, sr}, 0);
        rx_first = rsp_rx;
        for (int i = 0; i < resp_delay; i++) begin
            if (busy_poke && i == 5) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_SHIFT;
                cmd_tx    = L'($urandom);
            end
            if (busy_poke && i == 9) cmd_valid = 1'b0;
            @(negedge clk);
            if (busy_poke) begin
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_rx", rsp_rx, rx_first);
                chk("hold_cmd_ready", cmd_ready, 0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_cmd_ready", cmd_ready, 1);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("chain_after", chain_w, model_chain);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {se0, se1, sc0, sc1, sr, scan_si}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rx", rsp_rx, 0);

        preload(8'hA5);
        do_cmd(OP_SHIFT, 8'h3C, 0, 1'b0);
        func_d = 8'hF0;
        do_cmd(OP_CAPSHIFT, 8'h00, 1, 1'b0);
        do_cmd(OP_CLEAR, L'($urandom), 2, 1'b0);
        do_cmd(2'd3, L'($urandom), 0, 1'b0);
        preload(L'($urandom));
        do_cmd(OP_SHIFT, L'($urandom), 20, 1'b1);

        // Reset in the middle of shift slot 3.
        preload(L'($urandom));
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SHIFT;
        cmd_tx    = L'($urandom);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("mid_shift_se0", se0, 1);
        rstn = 1'b0;
        #1;
        chk("async_rst_ctrl", {se0, se1, sc0, sc1, sr, scan_si}, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("after_rst_cmd_ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        chk("after_rst_no_resp", rsp_valid, 0);
        preload(L'($urandom));
        do_cmd(OP_SHIFT, L'($urandom), 1, 1'b0);

        for (int n = 0; n < 16; n++) begin
            func_d = L'($urandom);
            if ($urandom_range(0, 2) == 0) preload(L'($urandom));
            do_cmd(2'($urandom_range(0, 3)), L'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_scan_seq_ctrl.md
# io_scan_seq_ctrl

Sequencer for the chain of IO-tile scan flip-flops (p_io_scffi instances behind each pi_pad). It accepts host commands over a valid/ready port, drives the global scan controls SE0, SE1, SC0, SC1 and SR, shifts a CHAIN_LEN-bit pattern into the chain and returns the bits shifted out. It sits at fabric top level, between the configuration/test host and the IO ring.

## Interface
- CHAIN_LEN, 32: number of scan flops in the IO chain (2..256).
- CNT_W, $clog2(CHAIN_LEN+1): bit-counter width (derived).
- pi_pad_clk  in  1  controller clock. One clock; all logic on its rising edge.
- pi_pad_rstn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle; command accepted when valid&ready.
- cmd_op  in  2  0=CLEAR, 1=CAPTURE_SHIFT, 2=SHIFT, 3=reserved.
- cmd_tx  in  CHAIN_LEN  pattern to load; bit 0 is shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts the response.
- rsp_rx  out  CHAIN_LEN  bits shifted out; bit 0 is sampled first.
- rsp_err  out  1  the command was the reserved op.
- SE0  out  1  scan enable: flop loads DI (scan) instead of D.
- SE1  out  1  chain mode: asserted for the whole non-CLEAR command.
- SC0, SC1  out  1  non-overlapping two-phase scan clock gates.
- SR  out  1  synchronous chain reset.
- scan_si  out  1  serial data into the first flop's DI (pi_pad_sc_in).
- scan_so  in  1  serial data from the last flop's SQ (pi_pad_sc_out).

## Operation
- States: IDLE, CLR, CAP, SHIFT, RESP.
- IDLE: cmd_ready=1. On accept, latch cmd_op and cmd_tx into tx_sr, clear rx_sr, then branch:
  - CLEAR → CLR.
  - CAPTURE_SHIFT → CAP.
  - SHIFT → SHIFT.
  - reserved → RESP with rsp_err=1 and rsp_rx=0.
- CLR: SR=1 for 2 cycles, then RESP with rsp_rx=0.
- CAP: SE1=1, SE0=0. One 4-cycle slot (SC0, gap, SC1, gap) loads the functional D into every flop, then → SHIFT.
- SHIFT: SE1=1, SE0=1. Runs CHAIN_LEN bit slots of 4 cycles each:
  - Slot cycle 0: sample scan_so into rx_sr[bit]. scan_si = tx_sr[bit], held stable for the whole slot.
  - Cycle 1: SC0=1. Cycle 2: gap. Cycle 3: SC1=1.
  - Bit counter increments at the end of each slot. After slot CHAIN_LEN-1 → RESP.
- RESP: rsp_valid=1 holding rsp_rx/rsp_err; on rsp_ready → IDLE. SE0, SE1, SC0, SC1 and SR are all 0 in RESP.
- SC0 and SC1 are never high in the same cycle or in adjacent cycles.

## Timing
- All outputs reset to 0 except cmd_ready, which is 1 on the first cycle after reset release.
- Accept to rsp_valid:
  - CLEAR: 3 cycles.
  - SHIFT: 4·CHAIN_LEN+1 cycles.
  - CAPTURE_SHIFT: 4·CHAIN_LEN+5 cycles.
  - reserved: 1 cycle.
- cmd_ready is low from the cycle after accept until the cycle after the rsp handshake. No back-to-back accept in the handshake cycle.
- rsp_ready held low: stay in RESP indefinitely with data stable.
- rsp_ready high on the first RESP cycle: response completes in that cycle.
- Reset asserted mid-command: immediate return to IDLE, all control outputs 0, no response. Chain contents are undefined afterwards.
- cmd_valid while busy is ignored. cmd_tx is sampled only on accept.

## Configuration
- IO_SCAN_CTRL_PARITY_EN defined:
  - Adds output rsp_par (1 bit) = XOR of rsp_rx, valid with rsp_valid.
  - Adds input cmd_par, checked against XOR of cmd_tx on accept. On mismatch the command is not run; go to RESP with rsp_err=1.
- Macro undefined: neither port exists, and rsp_err flags only the reserved op.

## Structure
- Package io_scan_pkg holds:
  - enum scan_state_t (IDLE, CLR, CAP, SHIFT, RESP);
  - scan_op_t localparams OP_CLEAR=2'd0, OP_CAPSHIFT=2'd1, OP_SHIFT=2'd2;
  - SLOT_CYC=4 and SR_CYC=2.
- One sub-module io_scan_phase_gen: a 2-bit slot-phase counter emitting sample, SC0 and SC1 strobes plus end-of-slot. The FSM and shift registers stay in the top.

## Test plan
- Reset, then idle: all control outputs 0, cmd_ready=1, rsp_valid=0.
- CHAIN_LEN=8 behavioural chain preloaded 8'hA5, SHIFT with cmd_tx=8'h3C:
  - rsp_rx=8'hA5 (bit-order per the rules above);
  - chain then holds 8'h3C;
  - rsp_valid 33 cycles after accept.
- CAPTURE_SHIFT with functional D=8'hF0, cmd_tx=0: rsp_rx=8'hF0, latency 37 cycles, exactly 9 SC0 and 9 SC1 pulses, never overlapping or adjacent.
- CLEAR: SR high exactly 2 cycles, rsp_rx=0, rsp_err=0. Reserved op 3: rsp_err=1 after 1 cycle, no SC pulses.
- rsp_ready held low 20 cycles: rsp_valid and data stable, cmd_ready=0, second cmd_valid ignored.
- Reset asserted at bit 3 of SHIFT: outputs 0 asynchronously, IDLE after release, next SHIFT completes normally.
